alu_mdu_iter: RTL
=================

Name: alu_mdu_iter

Overview:
- Parametrised, sequential successor of the single-cycle ALU.
- Executes all RV32I ALU operations and the full M extension through a valid/ready handshake.
- Uses an iterative shift-add multiplier (optional single-cycle), an iterative restoring divider, and explicit RISC-V divide-by-zero and overflow semantics.
- Sits in the execute stage of the multicycle and pipelined cores; the core stalls on oReady low.

Parameters:
- WIDTH, 32, datapath width. Power of two, >= 8; shift amount is iB[$clog2(WIDTH)-1:0].
- FAST_MUL, 0, 1 = multiply completes in 1 cycle (combinational product registered); 0 = iterative, WIDTH cycles.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iValid  in  1  operation request.
- oReady  out  1  unit can accept an operation; high only in IDLE.
- iFlush  in  1  abort current operation.
- iControl  in  5  opcode, using the shared OP* constants (OPAND..OPREMU, OPNULL).
- iA  in  WIDTH  operand A.
- iB  in  WIDTH  operand B.
- oValid  out  1  one-cycle pulse: oResult holds a new result.
- oResult  out  WIDTH  result; held until the next completion.
- oDivZero  out  1  high with oValid when a DIV/DIVU/REM/REMU had iB = 0.

Behaviour:
- Reset (async, iRST = 1): state IDLE, oResult = 0, oValid = 0, oDivZero = 0, oReady = 1, all internal registers cleared.
- Accept: iValid & oReady & !iFlush at a rising edge. iControl, iA and iB are captured; later input changes are ignored.
- States:
  - IDLE -> DONE: base ops, FAST_MUL multiplies, special-case divides.
  - IDLE -> MUL: iterative multiply.
  - IDLE -> DIV: all other divides.
  - MUL -> DONE after WIDTH iterations.
  - DIV -> FIX after WIDTH iterations.
  - FIX -> DONE: sign correction.
  - DONE -> IDLE after 1 cycle.
- oValid = 1 only in DONE; oResult and oDivZero are registered on entry to DONE.
- Latency, from accept edge to the cycle oValid is high:
  - 1 cycle: base ops, OPNULL/undefined, FAST_MUL multiplies, divide special cases.
  - WIDTH+1 cycles: iterative multiply.
  - WIDTH+2 cycles: divide/remainder.
- Throughput is one operation per latency+1 cycles. oReady is low in MUL, DIV, FIX and DONE.
- Base ops match the previous ALU bit-exactly at WIDTH bits:
  - SLT/SLTU results are zero-extended 1/0.
  - SRA is arithmetic.
  - LUI passes iB through.
  - OPNULL and undefined codes give 0.
- Multiply: operands are sign/zero-extended to 2*WIDTH per variant (MUL/MULH signed x signed, MULHU unsigned x unsigned, MULHSU signed A x unsigned B).
  - MUL returns product[WIDTH-1:0]; the MULH* variants return product[2*WIDTH-1:WIDTH].
  - Iterative mode performs one shift-add per cycle on the extended magnitudes and negates the 2*WIDTH product in the last step when required.
- Divide: the signed variants work on magnitudes; in FIX, quotient sign = sign(A) xor sign(B) and remainder sign = sign(A).
  - iB = 0: quotient = all ones, remainder = iA, oDivZero = 1.
  - Signed overflow (iA = most-negative, iB = -1) on DIV/REM: quotient = most-negative, remainder = 0, oDivZero = 0.
- Flush:
  - iFlush in any state -> IDLE at the next edge; oValid is not asserted.
  - oResult keeps its previous value.
  - iFlush with iValid in the same cycle: flush wins and nothing is accepted.
  - iFlush during DONE suppresses nothing already visible, since that oValid is already high this cycle; the unit still returns to IDLE.
- Reset mid-operation: immediate return to the reset state; the result is discarded.
- iValid while oReady = 0 is ignored; the requester must hold its request.

Test Plan:
- Reset then ADD, iA = 7, iB = -3 -> oValid exactly 1 cycle after accept, oResult = 4, oReady back to 1 the next cycle; SRA of 0x80000000 by 4 -> 0xF8000000.
- FAST_MUL = 0, MULH, iA = -2, iB = 3 -> oValid at accept+33 cycles, oResult = 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL -> 0x00000001.
- DIV, iA = -7, iB = 2 -> oValid at accept+34 cycles, oResult = 0xFFFFFFFD (-3); REM on the same operands -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide special cases: DIVU 5/0 -> 0xFFFFFFFF with oDivZero = 1 at accept+1; REM 5/0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; REM 0x80000000 / -1 -> 0.
- Flush: start DIV, assert iFlush at iteration 10 -> oValid never rises, oReady = 1 the next cycle, oResult still holds the prior result; iFlush and iValid together -> not accepted.
- Async iRST asserted mid-MUL (between clock edges) -> oResult = 0 and oReady = 1 immediately; a randomized 10k-operation run against a reference model at WIDTH = 32 and WIDTH = 16, with FAST_MUL = 0 and 1, shows no mismatches.

Source files
------------

// File: rtl/alu_mdu_iter.sv
// Sequential RV32I ALU plus M-extension unit behind a valid/ready handshake.
// Multiply is iterative shift-add (or one cycle when FAST_MUL=1); divide is iterative restoring.
module alu_mdu_iter #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid,
    output logic             oReady,
    input  logic             iFlush,
    input  logic [4:0]       iControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oValid,
    output logic [WIDTH-1:0] oResult,
    output logic             oDivZero
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [4:0] OPAND    = 5'd0;
    localparam logic [4:0] OPOR     = 5'd1;
    localparam logic [4:0] OPXOR    = 5'd2;
    localparam logic [4:0] OPADD    = 5'd3;
    localparam logic [4:0] OPSUB    = 5'd4;
    localparam logic [4:0] OPSLT    = 5'd5;
    localparam logic [4:0] OPSLTU   = 5'd6;
    localparam logic [4:0] OPSLL    = 5'd7;
    localparam logic [4:0] OPSRL    = 5'd8;
    localparam logic [4:0] OPSRA    = 5'd9;
    localparam logic [4:0] OPLUI    = 5'd10;
    localparam logic [4:0] OPMUL    = 5'd11;
    localparam logic [4:0] OPMULH   = 5'd12;
    localparam logic [4:0] OPMULHSU = 5'd13;
    localparam logic [4:0] OPMULHU  = 5'd14;
    localparam logic [4:0] OPDIV    = 5'd15;
    localparam logic [4:0] OPDIVU   = 5'd16;
    localparam logic [4:0] OPREM    = 5'd17;
    localparam logic [4:0] OPREMU   = 5'd18;
    localparam logic [4:0] OPNULL   = 5'd31;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]         state_q, state_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [4:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               dz_q, dz_d;

    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   base_res;
    logic               is_mul, is_div, a_sgn_op, b_sgn_op;
    logic               sa, sb;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod_fast;
    logic [WIDTH-1:0]   fast_res;
    logic               last;
    logic [2*WIDTH-1:0] acc_step, prod_fin;
    logic [WIDTH-1:0]   mul_res;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign shamt = iB[SW-1:0];

    always_comb begin
        base_res = '0;
        case (iControl)
            OPAND:   base_res = iA & iB;
            OPOR:    base_res = iA | iB;
            OPXOR:   base_res = iA ^ iB;
            OPADD:   base_res = iA + iB;
            OPSUB:   base_res = iA - iB;
            OPSLT:   base_res = {{(WIDTH-1){1'b0}}, $signed(iA) < $signed(iB)};
            OPSLTU:  base_res = {{(WIDTH-1){1'b0}}, iA < iB};
            OPSLL:   base_res = iA << shamt;
            OPSRL:   base_res = iA >> shamt;
            OPSRA:   base_res = WIDTH'($signed(iA) >>> shamt);
            OPLUI:   base_res = iB;
            default: base_res = '0;
        endcase
    end

    assign is_mul   = iControl inside {OPMUL, OPMULH, OPMULHSU, OPMULHU};
    assign is_div   = iControl inside {OPDIV, OPDIVU, OPREM, OPREMU};
    assign a_sgn_op = iControl inside {OPMUL, OPMULH, OPMULHSU, OPDIV, OPREM};
    assign b_sgn_op = iControl inside {OPMUL, OPMULH, OPDIV, OPREM};
    assign sa       = a_sgn_op & iA[WIDTH-1];
    assign sb       = b_sgn_op & iB[WIDTH-1];
    // Magnitudes fit in WIDTH bits unsigned, including the most-negative value.
    assign a_mag    = sa ? -iA : iA;
    assign b_mag    = sb ? -iB : iB;

    assign a_ext     = a_sgn_op ? {{WIDTH{iA[WIDTH-1]}}, iA} : {{WIDTH{1'b0}}, iA};
    assign b_ext     = b_sgn_op ? {{WIDTH{iB[WIDTH-1]}}, iB} : {{WIDTH{1'b0}}, iB};
    assign prod_fast = a_ext * b_ext;
    assign fast_res  = (iControl == OPMUL) ? prod_fast[WIDTH-1:0] : prod_fast[2*WIDTH-1:WIDTH];

    assign last     = (cnt_q == SW'(WIDTH - 1));
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign prod_fin = neg_q ? -acc_step : acc_step;
    assign mul_res  = (op_q == OPMUL) ? prod_fin[WIDTH-1:0] : prod_fin[2*WIDTH-1:WIDTH];

    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign q_fix = neg_q  ? -quo_q : quo_q;
    assign r_fix = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        res_d    = res_q;
        dz_d     = dz_q;

        if (iFlush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iValid) begin
                        op_d  = iControl;
                        cnt_d = '0;
                        if (is_mul) begin
                            if (FAST_MUL) begin
                                res_d   = fast_res;
                                dz_d    = 1'b0;
                                state_d = S_DONE;
                            end else begin
                                acc_d    = '0;
                                mcand_d  = {{WIDTH{1'b0}}, a_mag};
                                mplier_d = b_mag;
                                neg_d    = sa ^ sb;
                                state_d  = S_MUL;
                            end
                        end else if (is_div) begin
                            if (iB == '0) begin
                                res_d   = (iControl inside {OPDIV, OPDIVU}) ? '1 : iA;
                                dz_d    = 1'b1;
                                state_d = S_DONE;
                            end else if (b_sgn_op && iA == MIN_NEG && iB == '1) begin
                                res_d   = (iControl == OPDIV) ? MIN_NEG : '0;
                                dz_d    = 1'b0;
                                state_d = S_DONE;
                            end else begin
                                rem_d   = '0;
                                quo_d   = a_mag;
                                dvs_d   = b_mag;
                                neg_d   = sa ^ sb;
                                rneg_d  = sa;
                                state_d = S_DIV;
                            end
                        end else begin
                            res_d   = base_res;
                            dz_d    = 1'b0;
                            state_d = S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + SW'(1);
                    if (last) begin
                        res_d   = mul_res;
                        dz_d    = 1'b0;
                        state_d = S_DONE;
                    end
                end
                S_DIV: begin
                    // Restoring step: keep the difference only when it did not borrow.
                    rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d = cnt_q + SW'(1);
                    if (last) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    res_d   = (op_q inside {OPDIV, OPDIVU}) ? q_fix : r_fix;
                    dz_d    = 1'b0;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            res_q    <= res_d;
            dz_q     <= dz_d;
        end
    end

    assign oReady   = (state_q == S_IDLE);
    assign oValid   = (state_q == S_DONE);
    assign oResult  = res_q;
    assign oDivZero = dz_q;

endmodule
